mem_transfer_sequencer: RTL

//  Sequences a length-programmable transfer through two word memories, A and B.

---
 rtl/mem_transfer_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/mem_transfer_sequencer.sv
// mem_transfer_sequencer: fills memory A from a stream, then copies A into B word by word
module mem_transfer_sequencer #(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              in_valid,
    input  logic              b_ready,
    output logic              weA,
    output logic              incA,
    output logic              weB,
    output logic              incB,
    output logic [ADDR_W-1:0] addrA,
    output logic [ADDR_W-1:0] addrB,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, FILL, REWIND, RD_A, WR_B, DONE} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, cnt_q, cnt_d, len_q, len_d;
    logic last;
    assign last  = cnt_q == len_q - 1'b1;
    assign addrA = addr_a_q;
    assign addrB = addr_b_q;
    assign busy  = state_q != IDLE;
    // next-state, counters and combinational enables per phase
    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        weA      = 1'b0;
        incA     = 1'b0;
        weB      = 1'b0;
        incB     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                len_d    = len;
                cnt_d    = '0;
                addr_a_d = '0;
                addr_b_d = '0;
                state_d  = (len != '0) ? FILL : DONE;
            end
            FILL: begin
                weA  = in_valid;
                incA = in_valid;
                if (in_valid) begin
                    addr_a_d = addr_a_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = last ? REWIND : FILL;
                end
            end
            REWIND: begin
                addr_a_d = '0;
                cnt_d    = '0;
                state_d  = RD_A;
            end
            RD_A: state_d = WR_B;
            WR_B: begin
                weB = b_ready;
                if (b_ready) begin
                    incA     = 1'b1;
                    incB     = 1'b1;
                    addr_a_d = addr_a_q + 1'b1;
                    addr_b_d = addr_b_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = last ? DONE : RD_A;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_a_q <= '0;
            addr_b_q <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
        end
    end
endmodule
